// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch squashes,
// data-memory wait freezes with a watchdog, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             resetl,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             front_freeze,
   output logic             memwb_bubble,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [WC_W-1:0]   wait_cnt_reg;
   logic [WC_W-1:0]   wait_cnt_next;
   logic [CNT_W-1:0]  stall_cycles_reg;

   logic freeze;
   logic branch;
   logic luse;
   logic rs_match;

   always_comb begin
      freeze   = (state_reg == FAULT) | (mem_req & ~dmem_ready);
      branch   = ex_br_taken & ~freeze;
      rs_match = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
      // XZR is never a real destination, so it cannot create a hazard
      luse     = ex_memread & ex_regwrite & (ex_rd != 5'd31) & rs_match
                 & ~freeze & ~ex_br_taken;
   end

   always_comb begin
      pc_stall     = resetl & (freeze | luse);
      ifid_stall   = resetl & (freeze | luse);
      ifid_flush   = resetl & branch;
      idex_flush   = resetl & (branch | luse);
      front_freeze = resetl & freeze;
      memwb_bubble = resetl & freeze;
      mem_fault    = resetl & (state_reg == FAULT);
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         RUN: begin
            if (mem_req & ~dmem_ready) begin
               state_next    = MEM_WAIT;
               wait_cnt_next = WC_W'(1);
            end else begin
               wait_cnt_next = '0;
            end
         end
         MEM_WAIT: begin
            // a dropped request is treated as completion
            if (~mem_req | dmem_ready) begin
               state_next    = RUN;
               wait_cnt_next = '0;
            end else if (wait_cnt_reg == WC_W'(MEM_TIMEOUT - 1)) begin
               state_next    = FAULT;
            end else begin
               wait_cnt_next = wait_cnt_reg + WC_W'(1);
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next    = RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         state_reg        <= RUN;
         wait_cnt_reg     <= '0;
         stall_cycles_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (pc_stall && (stall_cycles_reg != {CNT_W{1'b1}})) begin
            stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
         end
      end
   end

   assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected controls/counts are queued as stimulus is
// driven and popped when outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        resetl;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, ex_br_taken;
   logic        mem_req, dmem_ready;

   logic        pc_stall, ifid_stall, ifid_flush, idex_flush, front_freeze, memwb_bubble, mem_fault;
   logic [31:0] stall_cycles;
   logic        pc_stall2, ifid_stall2, ifid_flush2, idex_flush2, front_freeze2, memwb_bubble2, mem_fault2;
   logic [3:0]  stall_cycles2;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .resetl(resetl),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_br_taken(ex_br_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .front_freeze(front_freeze), .memwb_bubble(memwb_bubble),
      .mem_fault(mem_fault), .stall_cycles(stall_cycles)
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
      .clk(clk), .resetl(resetl),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_br_taken(ex_br_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_stall2), .ifid_stall(ifid_stall2), .ifid_flush(ifid_flush2),
      .idex_flush(idex_flush2), .front_freeze(front_freeze2), .memwb_bubble(memwb_bubble2),
      .mem_fault(mem_fault2), .stall_cycles(stall_cycles2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_stall, ifid_stall, ifid_flush, idex_flush, front_freeze, memwb_bubble, mem_fault}
   localparam logic [6:0] C_IDLE = 7'b0000000;
   localparam logic [6:0] C_LUSE = 7'b1101000;
   localparam logic [6:0] C_BR   = 7'b0011000;
   localparam logic [6:0] C_FRZ  = 7'b1100110;
   localparam logic [6:0] C_FLT  = 7'b1100111;

   typedef struct {
      string      tag;
      logic [6:0] ctrl;
      int         cnt;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   exp_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic sample();
      exp_t e;
      int   sat;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e   = sb.pop_front();
         sat = (e.cnt > 15) ? 15 : e.cnt;
         chk({e.tag, "_ctrl"},
             {25'd0, pc_stall, ifid_stall, ifid_flush, idex_flush, front_freeze, memwb_bubble, mem_fault},
             {25'd0, e.ctrl});
         chk({e.tag, "_cnt"}, stall_cycles, 32'(e.cnt));
         chk({e.tag, "_ctrl_w4"},
             {25'd0, pc_stall2, ifid_stall2, ifid_flush2, idex_flush2, front_freeze2, memwb_bubble2, mem_fault2},
             {25'd0, e.ctrl});
         chk({e.tag, "_cnt_w4"}, {28'd0, stall_cycles2}, 32'(sat));
         $display("step %-12s ctrl=%b cnt=%0d cnt_w4=%0d", e.tag,
                  {pc_stall, ifid_stall, ifid_flush, idex_flush, front_freeze, memwb_bubble, mem_fault},
                  stall_cycles, stall_cycles2);
      end
   endtask

   task automatic push_exp(input string tag, input logic [6:0] ectrl);
      exp_t e;
      e.tag  = tag;
      e.ctrl = ectrl;
      e.cnt  = exp_cnt;
      sb.push_back(e);
      if (resetl && ectrl[6]) exp_cnt++;
   endtask

   // called at posedge+1; drives, queues expectation, samples at negedge, returns at posedge+1
   task automatic cyc(input string tag, input logic [6:0] ectrl);
      push_exp(tag, ectrl);
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr, input logic rw,
                         input logic br, input logic mq, input logic rdy);
      id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      ex_rd = rd; ex_memread = mr; ex_regwrite = rw; ex_br_taken = br;
      mem_req = mq; dmem_ready = rdy;
   endtask

   task automatic idle();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      resetl = 1'b0;
      // hazardous inputs while reset is held: outputs must stay 0
      set_in(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      cyc("rst_hold", C_IDLE);
      resetl = 1'b1;
      idle();
      cyc("idle", C_IDLE);

      // load-use on rs1, then the hazard clears
      set_in(5'd3, 5'd7, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("luse_rs1", C_LUSE);
      idle();
      cyc("luse_done", C_IDLE);
      set_in(5'd9, 5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("luse_rs2", C_LUSE);

      // no-hazard cases
      set_in(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("xzr", C_IDLE);
      set_in(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("no_use", C_IDLE);
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("no_regwr", C_IDLE);
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("not_load", C_IDLE);

      // taken branch overrides load-use
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc("br_luse", C_BR);
      idle();
      cyc("post_br", C_IDLE);

      // three wait cycles then ready; branch during freeze is ignored
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc("wait1_br", C_FRZ);
      idle(); mem_req = 1'b1; dmem_ready = 1'b0;
      cyc("wait2", C_FRZ);
      cyc("wait3", C_FRZ);
      dmem_ready = 1'b1;
      cyc("mem_ready", C_IDLE);
      idle();
      cyc("after_mem", C_IDLE);

      // request dropped mid-wait behaves as completion
      mem_req = 1'b1; dmem_ready = 1'b0;
      cyc("drop_wait", C_FRZ);
      mem_req = 1'b0;
      cyc("drop_req", C_IDLE);

      // watchdog: 16 frozen cycles, then sticky fault
      mem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 16; i++) cyc($sformatf("wd%0d", i), C_FRZ);
      cyc("fault0", C_FLT);
      set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc("fault_inps", C_FLT);
      idle();
      cyc("fault_idle", C_FLT);

      // asynchronous reset mid-fault clears everything immediately
      resetl = 1'b0;
      exp_cnt = 0;
      push_exp("rst_async", C_IDLE);
      #1;
      sample();
      @(posedge clk);
      #1;
      mem_req = 1'b1; dmem_ready = 1'b0;
      cyc("rst_low", C_IDLE);
      resetl = 1'b1;

      // long freeze: wide counter counts, 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), (i < 16) ? C_FRZ : C_FLT);
      idle();
      cyc("sat_end", C_FLT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
